// File: rtl/ppam_mac_accum.sv
// ============================================================================
// Module   : ppam_mac_accum
// Purpose  : Frame accumulator for 16-bit PPAM products, with valid/ready
//            handshakes on both ports and optional saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppam_mac_accum #(
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 16,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [7:0]       out_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [8:0] c_FRAME_LEN = FRAME_LEN[8:0];

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_start_state;
    logic             r_init;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [ACC_W:0]   w_sum;
    logic [8:0]       w_cnt_inc;
    logic             w_accept;
    logic             w_take;

    // r_init keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_init & ((r_state != S_HOLD) | out_ready);
    assign out_valid = (r_state == S_HOLD);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_cnt   = r_cnt;

    assign w_accept  = in_valid & in_ready & ~clr;
    assign w_take    = out_valid & out_ready & ~clr;
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(in_prod);
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    assign w_start_state = (in_last || (c_FRAME_LEN == 9'd1)) ? S_HOLD : S_ACCUM;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = 8'd0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = w_start_state;
                        w_acc_nxt   = ACC_W'(in_prod);
                        w_cnt_nxt   = 8'd1;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        w_cnt_nxt = w_cnt_inc[7:0];
                        if (w_sum[ACC_W]) begin
                            w_ovf_nxt = 1'b1;
                            w_acc_nxt = (SATURATE != 0) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
                        end else begin
                            w_acc_nxt = w_sum[ACC_W-1:0];
                        end
                        if (in_last || (w_cnt_inc == c_FRAME_LEN)) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Zero-bubble: a take with a same-cycle accept opens the next frame.
                    if (w_take) begin
                        if (w_accept) begin
                            w_state_nxt = w_start_state;
                            w_acc_nxt   = ACC_W'(in_prod);
                            w_cnt_nxt   = 8'd1;
                            w_ovf_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_init  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule

`default_nettype wire
